hd_beat_gen: RTL and testbench
==============================

// Module: hd_beat_gen
// PURPOSE
//  Machine-cycle timing generator for the hardwired controller. Produces the
//  clock phases T1/T2/T3 and the one-hot beat W[3:1] that the controller decodes.
//  Consumes the controller's SHORT/LONG/STOP requests to shorten, stretch or halt
//  the beat sequence. Starts on the front-panel QD button.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages on the asynchronous QD input (>=2)
//  CNT_W        8  width of the completed-instruction counter
// PORTS
//  CLK        in   1      master clock; all state changes on rising edge
//  CLR        in   1      asynchronous, active-low reset
//  QD         in   1      start button, asynchronous level, active-high
//  SSTEP      in   1      single-beat mode: halt after every beat
//  SHORT      in   1      from controller: current beat is the last of the cycle
//  LONG       in   1      from controller: insert W3 after W2
//  STOP       in   1      from controller: halt after the current beat
//  T1,T2,T3   out  1 each clock phases, one-hot while running, all 0 when halted
//  W          out  3      beat, one-hot {W3,W2,W1}
//  RUN        out  1      1 while phases are cycling
//  CYC_END    out  1      1 during the T3 cycle of the last beat of a machine cycle
//  INSTR_CNT  out  CNT_W  count of completed machine cycles
// BEHAVIOUR
//  Reset (CLR low, asynchronous): RUN=0, T1=T2=T3=0, W=3'b001, INSTR_CNT=0,
//   synchroniser and edge-detect flops =0, CYC_END=0. Reset overrides everything,
//   including mid-beat; no partial beat completes.
//  QD path: SYNC_STAGES-flop synchroniser, then rising-edge detect (qd_rise).
//   The edge is registered in the clock cycle after the synchroniser output rises.
//  States: HALT (RUN=0) and PH1/PH2/PH3 (T1/T2/T3 high, respectively).
//   HALT: if qd_rise, go to PH1 next cycle. W is unchanged. qd_rise is ignored
//    outside HALT.
//   PH1 -> PH2 -> PH3: one CLK each.
//   PH3 is the end of the beat. SHORT/LONG/STOP/SSTEP are sampled on the rising
//    edge that leaves PH3. The controller updates its state on T3 falling, which
//    coincides with this edge.
//  Beat transition at end of PH3:
//   W1: SHORT ? W1 : W2
//   W2: LONG ? W3 : W1
//   W3: W1 (SHORT and LONG ignored)
//  Leaving PH3: (STOP|SSTEP) ? HALT : PH1. W still advances as above, so restart
//   resumes at the next beat. Example: STOP in W1 with SHORT=0 halts with W=W2.
//  CYC_END = T3 & next-W==W1. This is combinational from registered state and
//   the sampled inputs.
//  INSTR_CNT increments by 1 on every PH3 exit with CYC_END=1, mod 2^CNT_W. It
//   wraps from all-ones to 0 silently.
//  Simultaneous SHORT and LONG in W1: SHORT wins, next beat is W1. LONG only
//   matters in W2.
//  STOP together with SHORT: the cycle ends, CYC_END=1, the count increments,
//   then HALT.
//  A QD press held across a STOP restarts only on a new rising edge.
//  Latency: one QD edge to T1 is SYNC_STAGES+1 CLKs. Each beat is 3 CLKs. A
//   machine cycle is 3, 6 or 9 CLKs.
//  W changes only on the PH3 exit edge. It is never 0 and never multi-hot.
// TESTING
//  1. Reset, then QD pulse. Required: T1 high 3 CLKs after the QD edge (SYNC_STAGES=2).
//     Phases cycle T1,T2,T3. With SHORT=LONG=0, W goes 001,010,001.
//  2. LONG=1 during W2. Required: W goes 001,010,100,001. CYC_END is pulsed once,
//     in the W3 T3 cycle. INSTR_CNT goes 0 to 1.
//  3. SHORT=1 in W1 for 4 beats. Required: W stays 001. CYC_END every 3rd CLK.
//     INSTR_CNT=4.
//  4. STOP in the W1 T3 cycle (SHORT=0). Required: RUN=0, T=000, W=010. The next
//     QD resumes at W2/T1.
//  5. SSTEP=1. Required: exactly one beat per QD press, and W advances by one beat
//     per press. Holding QD high does not retrigger.
//  6. CLR low during W2/PH2. Required: all outputs return to their reset values at
//     once. INSTR_CNT wraps 255 to 0 after 256 cycles with CNT_W=8.

Source files
------------

// File: rtl/hd_beat_gen.sv
// Machine-cycle timing generator for the hardwired controller: phases T1..T3 and
// one-hot beat W, shortened, stretched or halted on the controller's requests.
module hd_beat_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             QD,
    input  logic             SSTEP,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic [2:0]       W,
    output logic             RUN,
    output logic             CYC_END,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } state_t;

    localparam logic [2:0]       BEAT_W1 = 3'b001;
    localparam logic [2:0]       BEAT_W2 = 3'b010;
    localparam logic [2:0]       BEAT_W3 = 3'b100;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             w_next;
    logic [SYNC_STAGES-1:0] qd_sync;
    logic                   qd_prev;
    logic                   qd_rise;
    logic                   beat_end;

    // QD synchroniser and edge detector; the edge itself is combinational from
    // the flops so T1 follows the QD edge by SYNC_STAGES+1 clocks.
    // NOTE: every sequential block uses <= so all flops sample pre-edge values.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            qd_sync <= '0;
            qd_prev <= 1'b0;
        end else begin
            qd_sync <= {qd_sync[SYNC_STAGES-2:0], QD};
            qd_prev <= qd_sync[SYNC_STAGES-1];
        end
    end

    assign qd_rise  = qd_sync[SYNC_STAGES-1] & ~qd_prev;
    assign beat_end = (state == PH3);

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= HALT;
        else      state <= state_next;
    end

    // Next-state logic
    // NOTE: each always_comb assigns a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            HALT: if (qd_rise) state_next = PH1;
            PH1:  state_next = PH2;
            PH2:  state_next = PH3;
            PH3:  state_next = (STOP | SSTEP) ? HALT : PH1;
        endcase
    end

    // Beat successor; an illegal W recovers to W1
    always_comb begin
        w_next = BEAT_W1;
        case (W)
            BEAT_W1: w_next = SHORT ? BEAT_W1 : BEAT_W2;
            BEAT_W2: w_next = LONG  ? BEAT_W3 : BEAT_W1;
            default: w_next = BEAT_W1;
        endcase
    end

    // Output logic
    always_comb begin
        T1      = (state == PH1);
        T2      = (state == PH2);
        T3      = (state == PH3);
        RUN     = (state != HALT);
        CYC_END = beat_end && (w_next == BEAT_W1);
    end

    // Beat and completed-cycle count advance only on the PH3 exit edge
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            W         <= BEAT_W1;
            INSTR_CNT <= '0;
        end else begin
            if (beat_end) W <= w_next;
            if (CYC_END)  INSTR_CNT <= INSTR_CNT + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hd_beat_gen.sv
// Scoreboard bench for hd_beat_gen: each directed row pushes the expected outputs
// for one clock cycle; a negedge monitor pops and compares them.
module tb_hd_beat_gen;

    logic       clk;
    logic       clr;
    logic       qd, sstep, short_r, long_r, stop_r;
    logic       t1, t2, t3, run, cyc_end;
    logic [2:0] w;
    logic [7:0] instr_cnt;

    typedef struct {
        logic [2:0] t;     // {T3,T2,T1}
        logic [2:0] w;
        logic       ce;
        logic [7:0] cnt;
        int         test;
        int         row;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   test_no = 0;
    int   row_no  = 0;

    hd_beat_gen #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .CLK       (clk),
        .CLR       (clr),
        .QD        (qd),
        .SSTEP     (sstep),
        .SHORT     (short_r),
        .LONG      (long_r),
        .STOP      (stop_r),
        .T1        (t1),
        .T2        (t2),
        .T3        (t3),
        .W         (w),
        .RUN       (run),
        .CYC_END   (cyc_end),
        .INSTR_CNT (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] t, input logic [2:0] wv,
                                input logic ce, input logic [7:0] cnt);
        exp_t e;
        e.t    = t;
        e.w    = wv;
        e.ce   = ce;
        e.cnt  = cnt;
        e.test = test_no;
        e.row  = row_no;
        return e;
    endfunction

    // One clock cycle: inputs {QD,SSTEP,SHORT,LONG,STOP} held for the cycle,
    // and the outputs expected during it.
    task automatic vec(input logic [4:0] iv, input logic [2:0] t, input logic [2:0] wv,
                       input logic ce, input logic [7:0] cnt);
        @(posedge clk);
        #1;
        {qd, sstep, short_r, long_r, stop_r} = iv;
        sb.push_back(mk(t, wv, ce, cnt));
        row_no++;
    endtask

    // Assert CLR mid-cycle; reset values must appear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        clr = 1'b0;
        {qd, sstep, short_r, long_r, stop_r} = 5'b00000;
        sb.push_back(mk(3'b000, 3'b001, 1'b0, 8'd0));
        row_no++;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if ({t3, t2, t1} !== e.t || w !== e.w || cyc_end !== e.ce ||
                instr_cnt !== e.cnt || run !== (e.t != 3'b000)) begin
                n_bad++;
                $display("FAIL test%0d row%0d: got T=%b W=%b RUN=%b CYC_END=%b CNT=%0d, expected T=%b W=%b RUN=%b CYC_END=%b CNT=%0d",
                         e.test, e.row, {t3, t2, t1}, w, run, cyc_end, instr_cnt,
                         e.t, e.w, (e.t != 3'b000), e.ce, e.cnt);
            end
        end
    end

    initial begin
        logic [4:0] iv;
        logic       lg;
        clr = 1'b0;
        {qd, sstep, short_r, long_r, stop_r} = 5'b00000;

        // 1: reset values, QD pulse, then W1 -> W2 -> W1
        test_no = 1;
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd0);
        clr = 1'b1;
        vec(5'b10000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b10000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b001, 3'b001, 1'b0, 8'd0);   // T1, three clocks after QD
        vec(5'b00000, 3'b010, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b100, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b001, 3'b010, 1'b0, 8'd0);
        vec(5'b00000, 3'b010, 3'b010, 1'b0, 8'd0);
        vec(5'b00000, 3'b100, 3'b010, 1'b1, 8'd0);
        vec(5'b00000, 3'b001, 3'b001, 1'b0, 8'd1);

        // 2: LONG in W2 inserts W3; SHORT/LONG ignored in W3
        test_no = 2;
        vec(5'b00000, 3'b010, 3'b001, 1'b0, 8'd1);
        vec(5'b00000, 3'b100, 3'b001, 1'b0, 8'd1);
        vec(5'b00000, 3'b001, 3'b010, 1'b0, 8'd1);
        vec(5'b00000, 3'b010, 3'b010, 1'b0, 8'd1);
        vec(5'b00010, 3'b100, 3'b010, 1'b0, 8'd1);
        vec(5'b00000, 3'b001, 3'b100, 1'b0, 8'd1);
        vec(5'b00000, 3'b010, 3'b100, 1'b0, 8'd1);
        vec(5'b00110, 3'b100, 3'b100, 1'b1, 8'd1);

        // 3: SHORT in W1 for four beats
        test_no = 3;
        for (int b = 0; b < 4; b++) begin
            vec(5'b00100, 3'b001, 3'b001, 1'b0, 8'(2 + b));
            vec(5'b00100, 3'b010, 3'b001, 1'b0, 8'(2 + b));
            vec(5'b00100, 3'b100, 3'b001, 1'b1, 8'(2 + b));
        end

        // 4: STOP in W1/T3 halts with W=W2; next QD resumes at W2/T1
        test_no = 4;
        vec(5'b00000, 3'b001, 3'b001, 1'b0, 8'd6);
        vec(5'b00000, 3'b010, 3'b001, 1'b0, 8'd6);
        vec(5'b00001, 3'b100, 3'b001, 1'b0, 8'd6);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd6);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd6);
        vec(5'b10000, 3'b000, 3'b010, 1'b0, 8'd6);
        vec(5'b10000, 3'b000, 3'b010, 1'b0, 8'd6);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd6);
        vec(5'b00000, 3'b001, 3'b010, 1'b0, 8'd6);
        vec(5'b00000, 3'b010, 3'b010, 1'b0, 8'd6);
        vec(5'b00000, 3'b100, 3'b010, 1'b1, 8'd6);

        // 5: SSTEP - one beat per press, held QD does not retrigger
        test_no = 5;
        vec(5'b01000, 3'b001, 3'b001, 1'b0, 8'd7);
        vec(5'b01000, 3'b010, 3'b001, 1'b0, 8'd7);
        vec(5'b01000, 3'b100, 3'b001, 1'b0, 8'd7);
        vec(5'b01000, 3'b000, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b000, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b000, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b000, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b001, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b010, 3'b010, 1'b0, 8'd7);
        vec(5'b11000, 3'b100, 3'b010, 1'b1, 8'd7);
        for (int i = 0; i < 4; i++)
            vec(5'b11000, 3'b000, 3'b001, 1'b0, 8'd8);
        for (int i = 0; i < 3; i++)
            vec(5'b01000, 3'b000, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b000, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b000, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b000, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b001, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b010, 3'b001, 1'b0, 8'd8);
        vec(5'b11000, 3'b100, 3'b001, 1'b0, 8'd8);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd8);

        // 6: CLR during W2/PH2, then counter wrap with SHORT (and LONG) in W1
        test_no = 6;
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd8);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd8);
        vec(5'b10000, 3'b000, 3'b010, 1'b0, 8'd8);
        vec(5'b10000, 3'b000, 3'b010, 1'b0, 8'd8);
        vec(5'b00000, 3'b000, 3'b010, 1'b0, 8'd8);
        vec(5'b00000, 3'b001, 3'b010, 1'b0, 8'd8);
        async_reset();
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd0);
        clr = 1'b1;
        vec(5'b10000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b10000, 3'b000, 3'b001, 1'b0, 8'd0);
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd0);
        for (int k = 0; k <= 256; k++) begin
            lg = k[0];
            iv = {1'b0, 1'b0, 1'b1, lg, 1'b0};
            vec(iv, 3'b001, 3'b001, 1'b0, 8'(k % 256));
            vec(iv, 3'b010, 3'b001, 1'b0, 8'(k % 256));
            iv[0] = (k == 256);   // STOP with SHORT on the final beat
            vec(iv, 3'b100, 3'b001, 1'b1, 8'(k % 256));
        end
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd1);
        vec(5'b00000, 3'b000, 3'b001, 1'b0, 8'd1);

        repeat (4) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected rows never compared, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
